// File: rtl/instr_mem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package instr_mem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    WRITE,
    DONE
  } loader_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/instr_mem_loader_if.sv
// Host-side request/stream bus and instruction memory write port of the loader.
interface instr_mem_loader_if #(
  parameter int NW_W = 9
);

  logic            load_start;
  logic [NW_W-1:0] num_words;
  logic            byte_valid;
  logic [7:0]      byte_data;
  logic            byte_ready;
  logic            wr_en;
  logic [31:0]     wr_addr;
  logic [31:0]     wr_data;
  logic            cpu_hold;
  logic            done;
  logic            error;

  modport master (
    output load_start, num_words, byte_valid, byte_data,
    input  byte_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error
  );

  modport slave (
    input  load_start, num_words, byte_valid, byte_data,
    output byte_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error
  );

endinterface

// File: rtl/instr_word_assembler.sv
// Packs accepted stream bytes little-endian into a 32-bit word; flags the 4th byte.
module instr_word_assembler
  import instr_mem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        take,
  input  logic [7:0]  byte_in,
  output logic        word_full,
  output logic [31:0] word
);

  logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]           word_q, word_d;

  // The counter wraps to zero on the 4th byte, so the next word starts clean.
  assign word_full = take && (cnt_q == BYTE_CNT_W'(BYTES_PER_WORD - 1));
  assign word      = word_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    cnt_d  = cnt_q;
    word_d = word_q;
    if (clear) begin
      cnt_d  = '0;
      word_d = '0;
    end else if (take) begin
      word_d[{cnt_q, 3'b000} +: 8] = byte_in;
      cnt_d                        = cnt_q + BYTE_CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Boot-time loader: streams bytes into instruction words, writes them to
// consecutive addresses, and holds the core in reset while loading.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  instr_mem_loader_if.slave  bus
);

  localparam int NW_W = $clog2(DEPTH) + 1;

  loader_state_t   state_q, state_d;
  logic [NW_W-1:0] num_words_q, num_words_d;
  logic [NW_W-1:0] index_q, index_d;
  logic [31:0]     wr_addr_q, wr_addr_d;
  logic            byte_ready_q, wr_en_q, cpu_hold_q, done_q;
  logic            error_q, error_d;

  logic        take;
  logic        start_ok;
  logic        word_full;
  logic [31:0] word;

  assign take     = bus.byte_valid && byte_ready_q;
  assign start_ok = (state_q == IDLE) && bus.load_start &&
                    (bus.num_words != '0) && (bus.num_words <= NW_W'(DEPTH));

  instr_word_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (start_ok),
    .take      (take),
    .byte_in   (bus.byte_data),
    .word_full (word_full),
    .word      (word)
  );

  always_comb begin
    state_d     = state_q;
    num_words_d = num_words_q;
    index_d     = index_q;
    error_d     = error_q;
    unique case (state_q)
      IDLE: begin
        if (bus.load_start) begin
          if (bus.num_words == '0) begin
            error_d = 1'b0;
            state_d = DONE;
          end else if (bus.num_words > NW_W'(DEPTH)) begin
            error_d = 1'b1;
          end else begin
            num_words_d = bus.num_words;
            index_d     = '0;
            error_d     = 1'b0;
            state_d     = RECV;
          end
        end
      end
      RECV: begin
        if (word_full) state_d = WRITE;
      end
      WRITE: begin
        index_d = index_q + NW_W'(1);
        state_d = (index_d == num_words_q) ? DONE : RECV;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Address is captured on entry to WRITE, while index still names this word.
    wr_addr_d = (state_d == WRITE) ? BASE_ADDR + (32'(index_q) << 2) : wr_addr_q;
  end

  // Outputs are registered from the next state, so none of them depend
  // combinationally on byte_valid.
  // NOTE: the asynchronous reset clears every control and datapath flop here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      num_words_q  <= '0;
      index_q      <= '0;
      error_q      <= 1'b0;
      wr_addr_q    <= BASE_ADDR;
      byte_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      cpu_hold_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_words_q  <= num_words_d;
      index_q      <= index_d;
      error_q      <= error_d;
      wr_addr_q    <= wr_addr_d;
      byte_ready_q <= (state_d == RECV);
      wr_en_q      <= (state_d == WRITE);
      cpu_hold_q   <= (state_d != IDLE);
      done_q       <= (state_d == DONE);
    end
  end

  assign bus.byte_ready = byte_ready_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = word;
  assign bus.cpu_hold   = cpu_hold_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;

endmodule
